lsu_bus_ctrl: RTL

- Parametrised, multi-cycle load/store unit sitting between the RV32/RV64 execute stage and the data bus.
- Decodes load/store instructions and generates byte enables and lane-aligned store data.
- Decodes the target slave from the top address nibble over N configurable regions, then runs a req/ack handshake with a timeout.
- Returns sign- or zero-extended load data, stalls the pipeline until completion, and flags misalignment and bus errors.

---
 rtl/lsu_bus_ctrl_pkg.sv | 24 ++
 rtl/lsu_bus_ctrl_lane_align.sv | 49 ++++
 rtl/lsu_bus_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared constants and types for the load/store bus controller: opcodes,
// access-size encodings, FSM state type and default region tags.
package lsu_bus_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_S_TYPE = 7'b0100011;

  // funct3[1:0] access size; funct3[2] on a load selects zero-extension
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [3:0] DMEM_TAG = 4'h0;
  localparam logic [3:0] UART_TAG = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_bus_ctrl_lane_align.sv
// Combinational byte-lane alignment: store byte enables / shifted write data,
// and load extraction with sign or zero extension.
module lsu_lane_align
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                  size,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic                        unsigned_ld,
  input  logic [XLEN-1:0]             store_data,
  input  logic [XLEN-1:0]             load_raw,
  output logic [XLEN/8-1:0]           be,
  output logic [XLEN-1:0]             wdata,
  output logic [XLEN-1:0]             load_ext
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] shifted;
  logic            sign_bit;
  int              nbytes;
  int              nbits;

  always_comb begin
    nbytes = 1 << size;
    nbits  = 8 * nbytes;
    if (nbits > XLEN) nbits = XLEN;

    for (int i = 0; i < NB; i++) begin
      be[i] = (i >= int'(offset)) && (i < int'(offset) + nbytes);
    end
    wdata   = store_data << {offset, 3'b000};
    shifted = load_raw >> {offset, 3'b000};

    case (size)
      SIZE_B:  sign_bit = shifted[7];
      SIZE_H:  sign_bit = shifted[15];
      SIZE_W:  sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase

    // Bits above the access width replicate the sign bit unless zero-extending
    for (int i = 0; i < XLEN; i++) begin
      load_ext[i] = (i < nbits) ? shifted[i] : (!unsigned_ld && sign_bit);
    end
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Multi-cycle load/store unit: decodes the access, selects a slave by the top
// address nibble, runs a req/ack transaction with timeout and returns load data.
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int                      XLEN        = 32,
  parameter int                      NUM_SLAVES  = 2,
  parameter logic [NUM_SLAVES*4-1:0] REGION_TAGS = {UART_TAG, DMEM_TAG},
  parameter int                      TIMEOUT     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lsu_valid,
  input  logic [31:0]                  instruction,
  input  logic [XLEN-1:0]              dbus_address,
  input  logic [XLEN-1:0]              data,
  output logic                         lsu_stall,
  output logic [XLEN-1:0]              load_data,
  output logic                         load_valid,
  output logic                         misaligned,
  output logic                         bus_err,
  output logic                         bus_req,
  output logic                         bus_we,
  output logic                         bus_re,
  output logic [NUM_SLAVES-1:0]        bus_sel,
  output logic [XLEN-1:0]              bus_addr,
  output logic [XLEN-1:0]              bus_wdata,
  output logic [XLEN/8-1:0]            bus_be,
  input  logic [NUM_SLAVES*XLEN-1:0]   slave_rdata,
  input  logic [NUM_SLAVES-1:0]        slave_ack
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam int SW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  lsu_state_e state;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [1:0]      size;
  logic [OFFW-1:0] offset;
  logic            is_load;
  logic            is_store;
  logic            legal;
  logic            mem_op;
  logic            mis;
  logic            unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign size        = funct3[1:0];
  assign offset      = dbus_address[OFFW-1:0];
  assign unused_bits = ^{instruction[31:15], instruction[11:7]};

  // Dword accesses and LWU exist only on a 64-bit datapath; otherwise ignored
  always_comb begin
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_S_TYPE);
    legal    = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = (XLEN == 64);
        default:                                legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = (XLEN == 64);
        default:                legal = 1'b0;
      endcase
    end
  end

  assign mem_op = lsu_valid && legal;

  always_comb begin
    case (size)
      SIZE_H:  mis = offset[0];
      SIZE_W:  mis = |offset[1:0];
      SIZE_D:  mis = |dbus_address[2:0];
      default: mis = 1'b0;
    endcase
  end

  // Region decode; scanning downwards lets the lowest matching index win
  logic                  hit;
  logic [SW-1:0]         hit_idx;
  logic [NUM_SLAVES-1:0] hit_sel;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (dbus_address[XLEN-1 -: 4] == REGION_TAGS[4*i +: 4]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
    hit_sel = hit ? (NUM_SLAVES'(1) << hit_idx) : '0;
  end

  // Attributes of the access in flight, captured when leaving IDLE
  logic [1:0]            size_q;
  logic [OFFW-1:0]       off_q;
  logic                  uns_q;
  logic                  we_q;
  logic                  re_q;
  logic [SW-1:0]         idx_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [NB-1:0]         be_q;
  logic [CW-1:0]         cnt;

  logic [1:0]      align_size;
  logic [OFFW-1:0] align_off;
  logic [NB-1:0]   align_be;
  logic [XLEN-1:0] align_wdata;
  logic [XLEN-1:0] align_ldata;
  logic [XLEN-1:0] rdata_sel;
  logic            ack;

  assign align_size = (state == REQ) ? size_q : size;
  assign align_off  = (state == REQ) ? off_q  : offset;
  assign rdata_sel  = slave_rdata[idx_q*XLEN +: XLEN];
  assign ack        = |(slave_ack & sel_q);

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .size        (align_size),
    .offset      (align_off),
    .unsigned_ld (uns_q),
    .store_data  (data),
    .load_raw    (rdata_sel),
    .be          (align_be),
    .wdata       (align_wdata),
    .load_ext    (align_ldata)
  );

  // Handshake: bus_req rises on the cycle after decode and stays high with
  // stable sel/addr/be/wdata/strobes until the selected slave returns ack=1 on
  // a rising edge (or the timeout expires); bus_req then drops on the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bus_req    <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      idx_q      <= '0;
      sel_q      <= '0;
      be_q       <= '0;
    end else begin
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (mis) begin
              state      <= ERR;
              misaligned <= 1'b1;
              load_data  <= '0;
            end else if (!hit) begin
              state     <= ERR;
              bus_err   <= 1'b1;
              load_data <= '0;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              bus_req   <= 1'b1;
              bus_addr  <= {dbus_address[XLEN-1:OFFW], {OFFW{1'b0}}};
              bus_wdata <= align_wdata;
              be_q      <= align_be;
              size_q    <= size;
              off_q     <= offset;
              uns_q     <= funct3[2];
              we_q      <= is_store;
              re_q      <= is_load;
              idx_q     <= hit_idx;
              sel_q     <= hit_sel;
            end
          end
        end
        REQ: begin
          // An ack arriving on the expiry cycle still completes the access
          if (ack) begin
            state   <= DONE;
            cnt     <= '0;
            bus_req <= 1'b0;
            if (re_q) begin
              load_valid <= 1'b1;
              load_data  <= align_ldata;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= ERR;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_err   <= 1'b1;
            load_data <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu_stall = !rst && (((state == IDLE) && mem_op) || (state == REQ));
  assign bus_we    = bus_req && we_q;
  assign bus_re    = bus_req && re_q;
  assign bus_sel   = bus_req ? sel_q : '0;
  assign bus_be    = bus_req ? be_q  : '0;

endmodule
